// File: rtl/cordic_pipe_param_if.sv
// Streaming handshake bundle for the parameterised CORDIC pipeline:
// input sample channel plus output result channel.
interface cordic_pipe_param_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_mode;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] y_in;
    logic signed [DATA_W-1:0] z_in;
    logic [TAG_W-1:0]         tag_in;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] x_out;
    logic signed [DATA_W-1:0] y_out;
    logic signed [DATA_W-1:0] z_out;
    logic                     mode_out;
    logic [TAG_W-1:0]         tag_out;

    modport master (
        output in_valid, in_mode, x_in, y_in, z_in, tag_in, out_ready,
        input  in_ready, out_valid, x_out, y_out, z_out, mode_out, tag_out
    );

    modport slave (
        input  in_valid, in_mode, x_in, y_in, z_in, tag_in, out_ready,
        output in_ready, out_valid, x_out, y_out, z_out, mode_out, tag_out
    );
endinterface

// File: rtl/cordic_pipe_param.sv
// Fully pipelined CORDIC (rotation/vectoring per sample) with global stall,
// DATA_W+2 internal precision and saturating outputs.
module cordic_pipe_param #(
    parameter int NUM_STAGES = 16,
    parameter int DATA_W     = 16,
    parameter int TAG_W      = 4
) (
    input logic                clk,
    input logic                reset,
    cordic_pipe_param_if.slave bus
);
    localparam int IW = DATA_W + 2;
    typedef logic signed [IW-1:0] ival_t;

    localparam ival_t SAT_MAX = ival_t'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam ival_t SAT_MIN = ival_t'(-(64'sd1 <<< (DATA_W - 1)));

    // atan(2^-i) scaled to Q2.(DATA_W-2); series evaluated at elaboration time
    function automatic ival_t atan_const(input int i);
        real t;
        real p;
        real s;
        if (i == 0) begin
            s = 0.78539816339744831;
        end else begin
            t = 1.0;
            for (int j = 0; j < i; j++) begin
                t = t / 2.0;
            end
            p = t;
            s = 0.0;
            for (int n = 0; n < 30; n++) begin
                s = s + (((n % 2) == 0) ? p : -p) / real'(2 * n + 1);
                p = p * t * t;
            end
        end
        for (int j = 0; j < DATA_W - 2; j++) begin
            s = s * 2.0;
        end
        return ival_t'($rtoi(s + 0.5));
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input ival_t v);
        logic signed [DATA_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[DATA_W-1:0];
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

    logic advance_s;
    logic in_ready_s;
    logic accept_s;

    // Whole pipeline moves together; only a held result blocks it
    assign advance_s  = ~(bus.out_valid & ~bus.out_ready);
    assign in_ready_s = ~reset & advance_s;
    assign accept_s   = bus.in_valid & in_ready_s;
    assign bus.in_ready = in_ready_s;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam bit    LAST   = (k == NUM_STAGES - 1);
        localparam int    RW     = LAST ? DATA_W : IW;
        localparam ival_t ATAN_K = atan_const(k);

        ival_t            cx_s, cy_s, cz_s;
        ival_t            nx_s, ny_s, nz_s;
        logic             cv_s, cm_s, dpos_s;
        logic [TAG_W-1:0] ct_s;

        logic signed [RW-1:0] rx_s, ry_s, rz_s;
        logic signed [RW-1:0] x_r, y_r, z_r;
        logic                 v_r, m_r;
        logic [TAG_W-1:0]     t_r;

        if (k == 0) begin : g_src
            // A non-accepted cycle injects a zeroed bubble
            assign cx_s = accept_s ? ival_t'(bus.x_in) : {IW{1'b0}};
            assign cy_s = accept_s ? ival_t'(bus.y_in) : {IW{1'b0}};
            assign cz_s = accept_s ? ival_t'(bus.z_in) : {IW{1'b0}};
            assign cv_s = accept_s;
            assign cm_s = accept_s ? bus.in_mode : 1'b0;
            assign ct_s = accept_s ? bus.tag_in : {TAG_W{1'b0}};
        end else begin : g_src
            assign cx_s = g_stage[k-1].x_r;
            assign cy_s = g_stage[k-1].y_r;
            assign cz_s = g_stage[k-1].z_r;
            assign cv_s = g_stage[k-1].v_r;
            assign cm_s = g_stage[k-1].m_r;
            assign ct_s = g_stage[k-1].t_r;
        end

        // One CORDIC micro-rotation; direction from z (rotation) or y (vectoring)
        always_comb begin
            dpos_s = cm_s ? cy_s[IW-1] : ~cz_s[IW-1];
            if (dpos_s) begin
                nx_s = cx_s - (cy_s >>> k);
                ny_s = cy_s + (cx_s >>> k);
                nz_s = cz_s - ATAN_K;
            end else begin
                nx_s = cx_s + (cy_s >>> k);
                ny_s = cy_s - (cx_s >>> k);
                nz_s = cz_s + ATAN_K;
            end
        end

        if (LAST) begin : g_out
            assign rx_s = saturate(nx_s);
            assign ry_s = saturate(ny_s);
            assign rz_s = saturate(nz_s);
        end else begin : g_mid
            assign rx_s = nx_s;
            assign ry_s = ny_s;
            assign rz_s = nz_s;
        end

        // Stage register: cleared by reset, loaded only when the pipe advances
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                x_r <= {RW{1'b0}};
                y_r <= {RW{1'b0}};
                z_r <= {RW{1'b0}};
                v_r <= 1'b0;
                m_r <= 1'b0;
                t_r <= {TAG_W{1'b0}};
            end else if (advance_s) begin
                x_r <= rx_s;
                y_r <= ry_s;
                z_r <= rz_s;
                v_r <= cv_s;
                m_r <= cm_s;
                t_r <= ct_s;
            end
        end
    end

    assign bus.out_valid = g_stage[NUM_STAGES-1].v_r;
    assign bus.x_out     = g_stage[NUM_STAGES-1].x_r;
    assign bus.y_out     = g_stage[NUM_STAGES-1].y_r;
    assign bus.z_out     = g_stage[NUM_STAGES-1].z_r;
    assign bus.mode_out  = g_stage[NUM_STAGES-1].m_r;
    assign bus.tag_out   = g_stage[NUM_STAGES-1].t_r;
endmodule

// File: tb/tb_cordic_pipe_param.sv
// Directed self-checking bench for cordic_pipe_param: single vectors,
// a mixed-mode stream under random backpressure, and mid-stream reset.
module tb_cordic_pipe_param;
    localparam int DATA_W     = 16;
    localparam int TAG_W      = 4;
    localparam int NUM_STAGES = 16;
    localparam int TOL        = 8;

    typedef struct {
        logic mode;
        int   x, y, z;
        int   ex, ey, ez;
        int   tol_y;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    vec_t vecs [5];

    int check_cnt = 0;
    int error_cnt = 0;

    always #5 clk = ~clk;

    cordic_pipe_param_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    cordic_pipe_param #(
        .NUM_STAGES(NUM_STAGES),
        .DATA_W    (DATA_W),
        .TAG_W     (TAG_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check_value(input string tag, input int obs, input int exp, input int tol);
        int diff;
        check_cnt++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            error_cnt++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic drive(input int idx, input int tagv);
        bus.in_mode = vecs[idx].mode;
        bus.x_in    = 16'(vecs[idx].x);
        bus.y_in    = 16'(vecs[idx].y);
        bus.z_in    = 16'(vecs[idx].z);
        bus.tag_in  = TAG_W'(tagv);
    endtask

    task automatic check_result(input string name, input int idx, input int tagv);
        check_value({name, "_x"},    int'(bus.x_out), vecs[idx].ex, TOL);
        check_value({name, "_y"},    int'(bus.y_out), vecs[idx].ey, vecs[idx].tol_y);
        check_value({name, "_z"},    int'(bus.z_out), vecs[idx].ez, TOL);
        check_value({name, "_mode"}, int'(bus.mode_out), int'(vecs[idx].mode), 0);
        check_value({name, "_tag"},  int'(bus.tag_out), tagv % 16, 0);
    endtask

    task automatic run_single(input string name, input int idx, input int tagv);
        int lat;
        @(negedge clk);
        drive(idx, tagv);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check_value({name, "_in_ready"}, int'(bus.in_ready), 1, 0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check_value({name, "_latency"}, lat, NUM_STAGES, 0);
        check_result(name, idx, tagv);
    endtask

    initial begin
        int sent, rcvd, cyc, extra;
        logic prev_stall;
        int sx, sy, sz, sm, st;

        vecs[0] = '{1'b0,   9949,      0,     0, 16384,      0,     0, TOL};
        vecs[1] = '{1'b0,   9949,      0, 12868, 11585,  11585,     0, TOL};
        vecs[2] = '{1'b1,   8192,   8192,     0, 19078,      0, 12868, TOL};
        vecs[3] = '{1'b0,  16384,  16384, 12868,     0,  32767,     0, 0};
        vecs[4] = '{1'b0, -16384, -16384, 12868,     0, -32768,     0, 0};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(0, 0);
        #1;
        check_value("rst_out_valid", int'(bus.out_valid), 0, 0);
        check_value("rst_in_ready",  int'(bus.in_ready), 0, 0);
        check_value("rst_x_out",     int'(bus.x_out), 0, 0);
        check_value("rst_z_out",     int'(bus.z_out), 0, 0);
        check_value("rst_tag_out",   int'(bus.tag_out), 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        run_single("rot_k",     0, 3);
        run_single("rot_pi4",   1, 5);
        run_single("vec_45",    2, 10);
        run_single("sat_pos",   3, 12);
        run_single("sat_neg",   4, 15);

        // Mixed-mode stream with random backpressure
        sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0;
        sx = 0; sy = 0; sz = 0; sm = 0; st = 0;
        while (rcvd < 20 && cyc < 1000) begin
            @(negedge clk);
            if (prev_stall) begin
                check_value("hold_x",    int'(bus.x_out), sx, 0);
                check_value("hold_y",    int'(bus.y_out), sy, 0);
                check_value("hold_z",    int'(bus.z_out), sz, 0);
                check_value("hold_mode", int'(bus.mode_out), sm, 0);
                check_value("hold_tag",  int'(bus.tag_out), st, 0);
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            if (sent < 20) begin
                drive(sent % 5, sent % 16);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            check_value("in_ready_rule", int'(bus.in_ready),
                        int'(!(bus.out_valid && !bus.out_ready)), 0);
            if (bus.out_valid && bus.out_ready) begin
                check_result("stream", rcvd % 5, rcvd % 16);
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            prev_stall = bus.out_valid && !bus.out_ready;
            sx = int'(bus.x_out); sy = int'(bus.y_out); sz = int'(bus.z_out);
            sm = int'(bus.mode_out); st = int'(bus.tag_out);
            cyc++;
        end
        check_value("stream_count", rcvd, 20, 0);

        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        check_value("stream_no_dup", extra, 0, 0);

        // Reset with samples in flight and the head result stalled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(i, i);
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_value("pre_reset_valid", int'(bus.out_valid), 1, 0);
        #1;
        reset = 1'b1;
        #1;
        check_value("async_out_valid", int'(bus.out_valid), 0, 0);
        check_value("async_in_ready",  int'(bus.in_ready), 0, 0);
        check_value("async_x_out",     int'(bus.x_out), 0, 0);
        check_value("async_tag_out",   int'(bus.tag_out), 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        check_value("no_stale_after_rst", extra, 0, 0);
        run_single("post_rst", 1, 9);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end
endmodule
